// File: rtl/sd_rrarb.sv
// Round-robin arbiter feeding one srdy/drdy output register with grant tag.
// Define SD_RRARB_LOCK_EN to hold the grant for multi-word packets (c_eop).
module sd_rrarb #(
  parameter int width  = 16,
  parameter int inputs = 4,
  localparam int iw    = $clog2(inputs)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [inputs-1:0]       c_srdy,
  output logic [inputs-1:0]       c_drdy,
  input  logic [inputs*width-1:0] c_data,
`ifdef SD_RRARB_LOCK_EN
  input  logic [inputs-1:0]       c_eop,
`endif
  output logic                    p_srdy,
  input  logic                    p_drdy,
  output logic [width-1:0]        p_data,
  output logic [iw-1:0]           p_grant
);

  logic [iw-1:0] last;
  logic [iw-1:0] rr_winner;
  logic          rr_found;
  logic [iw-1:0] winner;
  logic          found;
  logic          load;
  logic [iw-1:0] idx;

`ifdef SD_RRARB_LOCK_EN
  typedef enum logic {ARB, LOCK} state_t;
  state_t        state;
  logic [iw-1:0] owner;
`endif

  // reset gates load so no requester sees drdy while held in reset
  assign load = reset & (~p_srdy | p_drdy);

  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    idx       = '0;
    for (int k = 1; k <= inputs; k++) begin
      idx = iw'((int'(last) + k) % inputs);
      if (!rr_found && c_srdy[idx]) begin
        rr_found  = 1'b1;
        rr_winner = idx;
      end
    end
  end

  always_comb begin
    found  = rr_found;
    winner = rr_winner;
`ifdef SD_RRARB_LOCK_EN
    if (state == LOCK) begin
      found  = c_srdy[owner];
      winner = owner;
    end
`endif
  end

  always_comb begin
    c_drdy = '0;
    if (load && found)
      c_drdy[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_srdy  <= 1'b0;
      p_data  <= '0;
      p_grant <= '0;
      last    <= iw'(inputs - 1);
`ifdef SD_RRARB_LOCK_EN
      state   <= ARB;
      owner   <= '0;
`endif
    end else if (load) begin
      if (found) begin
        p_srdy  <= 1'b1;
        p_data  <= c_data[int'(winner)*width +: width];
        p_grant <= winner;
        last    <= winner;
`ifdef SD_RRARB_LOCK_EN
        unique case (state)
          ARB: if (!c_eop[winner]) begin
            state <= LOCK;
            owner <= winner;
          end
          LOCK: if (c_eop[owner])
            state <= ARB;
          default: state <= ARB;
        endcase
`endif
      end else begin
        p_srdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sd_rrarb.sv
// Directed self-checking bench for sd_rrarb (inputs=4, width=16).
// Lock-mode steps are built only with SD_RRARB_LOCK_EN.
module tb_sd_rrarb;

  logic        clk;
  logic        reset;
  logic [3:0]  c_srdy;
  logic [3:0]  c_drdy;
  logic [63:0] c_data;
`ifdef SD_RRARB_LOCK_EN
  logic [3:0]  c_eop;
`endif
  logic        p_srdy;
  logic        p_drdy;
  logic [15:0] p_data;
  logic [1:0]  p_grant;

  int checks;
  int passed;

  sd_rrarb #(.width(16), .inputs(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (c_srdy),
    .c_drdy (c_drdy),
    .c_data (c_data),
`ifdef SD_RRARB_LOCK_EN
    .c_eop  (c_eop),
`endif
    .p_srdy (p_srdy),
    .p_drdy (p_drdy),
    .p_data (p_data),
    .p_grant(p_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] dval(input int i);
    return 16'(16'hD000 + i);
  endfunction

  function automatic logic [3:0] oh(input int i);
    return 4'(1 << (i % 4));
  endfunction

  initial begin
    checks = 0;
    passed = 0;
    reset  = 1'b0;
    c_srdy = 4'hF;
    p_drdy = 1'b1;
    c_data = {dval(3), dval(2), dval(1), dval(0)};
`ifdef SD_RRARB_LOCK_EN
    c_eop  = 4'b1111;
`endif

    // reset held with all requesters active
    step();
    step();
    check("rst_srdy", 32'(p_srdy), 32'd0);
    check("rst_drdy", 32'(c_drdy), 32'd0);
    check("rst_grant", 32'(p_grant), 32'd0);
    check("rst_data", 32'(p_data), 32'd0);

    // full load rotation
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("full_drdy", 32'(c_drdy), 32'(oh(i)));
      step();
      check("full_srdy", 32'(p_srdy), 32'd1);
      check("full_grant", 32'(p_grant), 32'(i % 4));
      check("full_data", 32'(p_data), 32'(dval(i % 4)));
    end

    // backpressure holds the word and blocks every requester
    p_drdy = 1'b0;
    #1;
    check("bp_drdy0", 32'(c_drdy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_drdy", 32'(c_drdy), 32'd0);
      check("bp_data", 32'(p_data), 32'(dval(3)));
      check("bp_grant", 32'(p_grant), 32'd3);
      check("bp_srdy", 32'(p_srdy), 32'd1);
    end
    p_drdy = 1'b1;
    #1;
    check("bp_rel_drdy", 32'(c_drdy), 32'(oh(0)));
    step();
    check("bp_rel_grant", 32'(p_grant), 32'd0);
    check("bp_rel_data", 32'(p_data), 32'(dval(0)));

    // sparse requests: get last=2, then only 1 and 3 request
    c_srdy = 4'b0100;
    #1;
    check("sp_drdy2", 32'(c_drdy), 32'(oh(2)));
    step();
    check("sp_grant2", 32'(p_grant), 32'd2);
    c_srdy = 4'b1010;
    #1;
    check("sp_drdy_a", 32'(c_drdy), 32'(oh(3)));
    step();
    check("sp_grant_a", 32'(p_grant), 32'd3);
    check("sp_data_a", 32'(p_data), 32'(dval(3)));
    check("sp_drdy_b", 32'(c_drdy), 32'(oh(1)));
    step();
    check("sp_grant_b", 32'(p_grant), 32'd1);
    check("sp_drdy_c", 32'(c_drdy), 32'(oh(3)));
    step();
    check("sp_grant_c", 32'(p_grant), 32'd3);

    // no requester: output empties, tag and data hold
    c_srdy = 4'b0000;
    #1;
    check("idle_drdy", 32'(c_drdy), 32'd0);
    step();
    check("idle_srdy", 32'(p_srdy), 32'd0);
    check("idle_grant", 32'(p_grant), 32'd3);
    check("idle_data", 32'(p_data), 32'(dval(3)));

    // mid-stream reset
    c_srdy = 4'hF;
    step();
    check("mr_grant0", 32'(p_grant), 32'd0);
    step();
    check("mr_grant1", 32'(p_grant), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mr_srdy_async", 32'(p_srdy), 32'd0);
    check("mr_drdy", 32'(c_drdy), 32'd0);
    step();
    check("mr_srdy_held", 32'(p_srdy), 32'd0);
    reset = 1'b1;
    #1;
    check("mr_rel_drdy", 32'(c_drdy), 32'(oh(0)));
    step();
    check("mr_rel_srdy", 32'(p_srdy), 32'd1);
    check("mr_rel_grant", 32'(p_grant), 32'd0);
    check("mr_rel_data", 32'(p_data), 32'(dval(0)));

`ifdef SD_RRARB_LOCK_EN
    // requester 1 sends a 3-word packet while 0 and 2 stay active
    c_srdy = 4'b0111;
    c_eop  = 4'b1101;
    #1;
    check("lk_drdy1", 32'(c_drdy), 32'(oh(1)));
    step();
    check("lk_grant1", 32'(p_grant), 32'd1);
    check("lk_drdy2", 32'(c_drdy), 32'(oh(1)));
    step();
    check("lk_grant2", 32'(p_grant), 32'd1);
    c_eop = 4'b1111;
    #1;
    check("lk_drdy3", 32'(c_drdy), 32'(oh(1)));
    step();
    check("lk_grant3", 32'(p_grant), 32'd1);
    check("lk_drdy4", 32'(c_drdy), 32'(oh(2)));
    step();
    check("lk_grant4", 32'(p_grant), 32'd2);
    check("lk_drdy5", 32'(c_drdy), 32'(oh(0)));
    step();
    check("lk_grant5", 32'(p_grant), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sd_rrarb.md
# sd_rrarb

Round-robin arbiter and output stage that shares one srdy/drdy pipeline among several requesters. Each requester presents an srdy/drdy/data channel. The block picks one winner per transfer, forwards its word through a single output register, and tags the word with the winner's index. It sits directly upstream of a shared pipeline (input stage, full buffer, output stage) so several producers can drive it without any external muxing.

## Interface
- width, 16, data bits per requester and on the output
- inputs, 4, number of requesters, legal range 2..16
- iw, $clog2(inputs), width of the grant index (derived; do not override)

- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset; asserting low clears all state immediately
- c_srdy  input  inputs  per-requester source ready
- c_drdy  output  inputs  per-requester destination ready; at most one bit set
- c_data  input  inputs*width  requester i uses bits [i*width +: width]
- c_eop  input  inputs  end-of-packet flag per requester; present only with SD_RRARB_LOCK_EN
- p_srdy  output  1  output word valid
- p_drdy  input  1  downstream ready
- p_data  output  width  output word
- p_grant  output  iw  index of the requester that produced p_data

## Operation
- A transfer occurs on any cycle where srdy and drdy are both 1 on the same channel.
- Output register state: p_srdy, p_data, p_grant, plus a pointer `last` (iw bits) holding the most recent winner.
- load = ~p_srdy | p_drdy. Loading is allowed when the register is empty or is draining this cycle.
- Winner selection: the first i with c_srdy[i]=1, searching from last+1 upward and wrapping modulo `inputs`. `last` itself is checked last.
- c_drdy[winner] = load. All other c_drdy bits are 0. If no c_srdy bit is set, c_drdy is 0.
- c_drdy may depend combinationally on c_srdy and p_drdy. Requesters must not make c_srdy depend on c_drdy.
- On a clock edge with load=1 and a winner present: p_data <= winner's data, p_grant <= winner, last <= winner, p_srdy <= 1.
- On a clock edge with load=1 and no winner: p_srdy <= 0. p_data, p_grant and last hold.
- With load=0, everything holds. A requester that has not been granted must keep its word stable until it is granted.
- Fairness: with all requesters continuously active, grants rotate 0,1,..,inputs-1,0,... Each requester waits at most inputs-1 transfers.

## Timing
- Reset values: p_srdy=0, p_data=0, p_grant=0, last=inputs-1 (so requester 0 wins first), c_drdy=0.
- Latency: a word accepted on cycle N appears on p_srdy/p_data in cycle N+1.
- Throughput: one word per cycle while p_drdy=1 and any requester is active.
- Backpressure: p_drdy=0 with p_srdy=1 drives every c_drdy bit to 0 combinationally in the same cycle.
- If p_drdy=1 and a new requester arrives in the same cycle, the output drains and reloads; no bubble cycle.
- Reset asserted mid-operation: the output word is dropped, p_srdy goes to 0 asynchronously, and last returns to inputs-1.
- The first arbitration after reset is released happens on the first rising edge at which reset is high.

## Configuration
- SD_RRARB_LOCK_EN defined:
  - Adds the c_eop port and a two-state FSM, ARB and LOCK.
  - ARB: selection is round-robin as above. A transfer with c_eop[winner]=0 moves to LOCK with owner=winner.
  - LOCK: only owner is considered, regardless of the other c_srdy bits. c_drdy[owner]=load. A transfer with c_eop[owner]=1 returns to ARB, and last <= owner.
  - A transfer with c_eop=1 in ARB (single-word packet) stays in ARB.
  - Reset forces ARB.
- SD_RRARB_LOCK_EN not defined: there is no c_eop port and no FSM. Every transfer is arbitrated independently.

## Test plan
- Reset check: hold reset=0 with all c_srdy=1 and p_drdy=1 → p_srdy=0 and c_drdy=0. After release, the first output has p_grant=0.
- Full load: inputs=4, all c_srdy=1 with distinct data, p_drdy=1 for 8 cycles → p_grant sequence 0,1,2,3,0,1,2,3, one word per cycle, data matches the source of each grant.
- Backpressure: p_drdy=0 for 5 cycles while p_srdy=1 → c_drdy=0 and p_data stable. On p_drdy=1 the held word transfers and the next requester is granted in the same cycle.
- Sparse requests with wrap: last=2, only c_srdy[1] and c_srdy[3] set → grant 3, then 1, then 3.
- Mid-stream reset: assert reset during a burst → p_srdy=0 immediately. After release, requester 0 is granted first and no stale word appears.
- Lock mode (SD_RRARB_LOCK_EN): requester 1 sends a 3-word packet (eop on word 3) while requesters 0 and 2 stay active → grants 1,1,1, then 2, then 0.
